sd_arbiter: RTL
===============

SD_ARBITER -- requirements
Module: sd_arbiter

Interface
REQ-001 Parameter TIMEOUT, 24'd12_000_000, cycles to wait in GRANT for sd_ack before abort.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 c_rd  in  2  per-client read request, level; bit i = client i.
REQ-005 c_wr  in  2  per-client write request, level.
REQ-006 c_lba  in  64  per-client LBA, client i at [32i+31:32i].
REQ-007 c_ack  out  2  per-client sd_ack, routed to granted client only.
REQ-008 c_buff_wr  out  2  per-client sd_buff_wr, routed to granted client only.
REQ-009 c_buff_din  in  16  per-client read-back byte, client i at [8i+7:8i].
REQ-010 c_done  out  2  one-cycle pulse: transfer for client i complete.
REQ-011 c_err  out  2  one-cycle pulse: request of client i timed out.
REQ-012 sd_lba  out  32  LBA to mist_io.
REQ-013 sd_rd  out  1  read request to mist_io, drive 0.
REQ-014 sd_wr  out  1  write request to mist_io, drive 0.
REQ-015 sd_ack  in  1  mist_io transfer acknowledge.
REQ-016 sd_buff_wr  in  1  mist_io buffer write strobe.
REQ-017 sd_buff_din  out  8  byte returned to mist_io during writes.
REQ-018 sd_buff_addr and sd_buff_dout SHALL be broadcast to clients outside this block; the block does not carry them.

Function
REQ-019 FSM states: IDLE, GRANT, XFER, DONE.
REQ-020 IDLE: a client is pending when c_rd[i]|c_wr[i]; if any is pending, the block SHALL enter GRANT on the next edge, latching grant index, c_lba of that client into sd_lba, and op (rd if c_rd set, else wr).
REQ-021 Arbitration: round-robin. With both clients pending, the client not served last wins. After reset, last-served = 1, so client 0 wins the first tie.
REQ-022 Same client asserts rd and wr together: read SHALL be served and write ignored for that grant.
REQ-023 GRANT: sd_rd/sd_wr SHALL be driven high from the latched op, registered, starting the first GRANT cycle. Client request changes SHALL be ignored.
REQ-024 GRANT: sd_ack rising SHALL move to XFER and deassert sd_rd/sd_wr on the same edge.
REQ-025 GRANT timeout: counter cleared on GRANT entry; at TIMEOUT cycles without sd_ack, the block SHALL drop sd_rd/sd_wr, pulse c_err[grant], and return to IDLE. last-served updates to grant.
REQ-026 XFER: sd_ack low SHALL move to DONE.
REQ-027 DONE: the block SHALL pulse c_done[grant] for exactly one cycle, update last-served, and return to IDLE. A new grant is possible the following cycle.
REQ-028 c_ack[i] = sd_ack & granted(i) & state in {GRANT, XFER}. This SHALL be combinational, zero latency.
REQ-029 c_buff_wr[i] = sd_buff_wr & granted(i) & state == XFER. This SHALL be combinational, keeping alignment with sd_buff_addr.
REQ-030 sd_buff_din = c_buff_din of the granted client in XFER, else 8'h00. This SHALL be combinational.
REQ-031 The non-granted client SHALL see c_ack, c_buff_wr, c_done and c_err all 0.
REQ-032 Clients SHALL drop requests on c_ack rise. A request still held after c_done is treated as a new request.
REQ-033 The timeout counter is 24 bits and saturates. It SHALL not wrap.

Reset
REQ-034 reset_n low SHALL asynchronously force state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, c_done=0, c_err=0, counter 0, and last-served=1.
REQ-035 While in reset, the combinational outputs c_ack, c_buff_wr and sd_buff_din SHALL be 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer with no c_done or c_err pulse. The requester re-requests.

Structure
REQ-037 Package sd_arb_pkg SHALL hold: the state enum, NCLIENTS=2, the TIMEOUT default, and the round-robin pick function.
REQ-038 No sub-module; the timeout counter and FSM are inline.

Verification
REQ-039 Single read: c_rd=2'b01, c_lba[31:0]=32'h1234 -> sd_rd=1 next cycle with sd_lba=32'h1234; model ack 4 cycles later -> sd_rd=0; 512 sd_buff_wr strobes reach only c_buff_wr[0]; sd_ack falls -> c_done=2'b01 for one cycle.
REQ-040 Contention: c_rd=2'b11 from reset -> client 0 served first, then client 1. Both request again -> client 0 after client 1 (alternation).
REQ-041 Write path: client 1 c_wr=1, c_buff_din[15:8]=8'hA5 -> sd_wr=1; during XFER sd_buff_din=8'hA5; in IDLE sd_buff_din=8'h00.
REQ-042 Timeout: TIMEOUT=100, no sd_ack -> sd_rd drops after 100 cycles, c_err=2'b01 one cycle, and the next pending client is granted.
REQ-043 Reset mid-XFER: reset_n low during XFER -> all outputs 0 immediately, no c_done. After release, a held request is re-granted.
REQ-044 rd+wr same client: c_rd[0]=c_wr[0]=1 -> only sd_rd asserted.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-client SD card arbiter.
package sd_arb_pkg;

   localparam int          NCLIENTS        = 2;
   localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12_000_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Round-robin pick between two clients: on a tie the client not served last wins.
   // Result is only meaningful when at least one client is pending.
   function automatic logic rr_pick(input logic [NCLIENTS-1:0] pending, input logic last);
      logic pick;
      if (pending[0] && pending[1]) begin
         pick = ~last;
      end else begin
         pick = pending[1];
      end
      return pick;
   endfunction

endpackage

// File: rtl/sd_arbiter.sv
// Two-client arbiter in front of the mist_io SD interface. One client owns the
// SD command/handshake at a time; ack and buffer strobes are routed to it only.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no owner; next pending client is granted on the next edge
// ST_GRANT | sd_rd/sd_wr asserted, waiting for sd_ack (bounded by TIMEOUT)
// ST_XFER  | sd_ack high, buffer strobes routed to the granted client
// ST_DONE  | one cycle: c_done pulse out, round-robin pointer updated
module sd_arbiter
   import sd_arb_pkg::*;
#(
   parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic [NCLIENTS-1:0]      c_rd,
   input  logic [NCLIENTS-1:0]      c_wr,
   input  logic [32*NCLIENTS-1:0]   c_lba,
   output logic [NCLIENTS-1:0]      c_ack,
   output logic [NCLIENTS-1:0]      c_buff_wr,
   input  logic [8*NCLIENTS-1:0]    c_buff_din,
   output logic [NCLIENTS-1:0]      c_done,
   output logic [NCLIENTS-1:0]      c_err,
   output logic [31:0]              sd_lba,
   output logic                     sd_rd,
   output logic                     sd_wr,
   input  logic                     sd_ack,
   input  logic                     sd_buff_wr,
   output logic [7:0]               sd_buff_din
);

   state_e               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 last_q, last_d;
   logic [31:0]          sd_lba_q, sd_lba_d;
   logic                 sd_rd_q, sd_rd_d;
   logic                 sd_wr_q, sd_wr_d;
   logic [NCLIENTS-1:0]  c_done_q, c_done_d;
   logic [NCLIENTS-1:0]  c_err_q, c_err_d;
   logic [23:0]          cnt_q, cnt_d;

   logic [NCLIENTS-1:0]  pending;
   logic                 pick;
   logic [NCLIENTS-1:0]  grant_oh;
   logic                 tmo_hit;
   logic [23:0]          cnt_inc;
   logic                 owned;

   assign pending  = c_rd | c_wr;
   assign pick     = rr_pick(pending, last_q);
   assign grant_oh = {grant_q, ~grant_q};
   // The current GRANT cycle is the TIMEOUT-th one without an ack.
   assign tmo_hit  = ({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT};
   // Saturating increment so a huge TIMEOUT can never see the counter wrap.
   assign cnt_inc  = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
   assign owned    = (state_q == ST_GRANT) || (state_q == ST_XFER);

   // Next-state, grant latch, timeout counter and registered pulse outputs.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      sd_lba_d = sd_lba_q;
      sd_rd_d  = sd_rd_q;
      sd_wr_d  = sd_wr_q;
      c_done_d = '0;
      c_err_d  = '0;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|pending) begin
               state_d  = ST_GRANT;
               grant_d  = pick;
               sd_lba_d = c_lba[{pick, 5'd0} +: 32];
               // Read wins when a client raises both at once.
               sd_rd_d  = c_rd[pick];
               sd_wr_d  = ~c_rd[pick];
               cnt_d    = '0;
            end
         end
         ST_GRANT: begin
            if (sd_ack) begin
               state_d = ST_XFER;
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
               c_err_d = grant_oh;
               last_d  = grant_q;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_XFER: begin
            if (!sd_ack) begin
               state_d  = ST_DONE;
               c_done_d = grant_oh;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            last_d  = grant_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer silently.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         sd_lba_q <= '0;
         sd_rd_q  <= 1'b0;
         sd_wr_q  <= 1'b0;
         c_done_q <= '0;
         c_err_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         sd_lba_q <= sd_lba_d;
         sd_rd_q  <= sd_rd_d;
         sd_wr_q  <= sd_wr_d;
         c_done_q <= c_done_d;
         c_err_q  <= c_err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Zero-latency routing so clients stay aligned with the broadcast buffer address.
   assign c_ack       = (sd_ack && owned) ? grant_oh : '0;
   assign c_buff_wr   = (sd_buff_wr && (state_q == ST_XFER)) ? grant_oh : '0;
   assign sd_buff_din = (state_q == ST_XFER) ? c_buff_din[{grant_q, 3'd0} +: 8] : 8'h00;

   assign sd_lba = sd_lba_q;
   assign sd_rd  = sd_rd_q;
   assign sd_wr  = sd_wr_q;
   assign c_done = c_done_q;
   assign c_err  = c_err_q;

endmodule
